// File: rtl/dram_port_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and the MEM stage.
// MEM has priority; IF is forced through after STARVE_LIMIT consecutive lost cycles.
module dram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic [3:0]        mem_wen_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_gnt_o,
  output logic              mem_rvalid_o,
  output logic [31:0]       mem_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IF  = 2'd1,
    RD_MEM = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       force_if;
  logic       if_gnt, mem_gnt;

  // Word-address slices drop the byte-lane bits and alias high addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  assign force_if = (starve_q == LIMIT);

  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (!reset_i) begin
      if (if_req_i && (!mem_req_i || force_if)) begin
        if_gnt = 1'b1;
      end else if (mem_req_i) begin
        mem_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o    = if_gnt;
  assign mem_gnt_o   = mem_gnt;
  assign ram_en_o    = if_gnt | mem_gnt;
  assign ram_wen_o   = mem_gnt ? mem_wen_i : 4'b0000;
  assign ram_addr_o  = mem_gnt ? mem_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
  assign ram_wdata_o = mem_wdata_i;

  always_comb begin
    starve_d = 4'd0;
    if (if_req_i && !if_gnt) begin
      starve_d = force_if ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Read-return FSM: state names the owner of the read issued last cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RD_IF;
    end else if (mem_gnt && (mem_wen_i == 4'b0000)) begin
      state_d = RD_MEM;
    end
  end

  // Gated by reset so a read in flight when reset arrives is never reported.
  always_comb begin
    if_rvalid_o  = 1'b0;
    mem_rvalid_o = 1'b0;
    if (!reset_i) begin
      if_rvalid_o  = (state_q == RD_IF);
      mem_rvalid_o = (state_q == RD_MEM);
    end
  end

  assign if_rdata_o  = ram_rdata_i;
  assign mem_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench: directed vector table, a starvation sequence, then random traffic
// against a transaction-level model of arbitration, read return and RAM contents.
module tb_dram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        reset;
  logic        if_req, mem_req;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
  logic [31:0] if_rdata, mem_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  dram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .reset_i(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_wen_i(mem_wen), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt), .mem_rvalid_o(mem_rvalid),
    .mem_rdata_o(mem_rdata), .ram_en_o(ram_en), .ram_wen_o(ram_wen),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 2) return 32'h11223344;
    return 32'hA5000000 ^ (i * 32'h00010003);
  endfunction

  // RAM macro model: synchronous read, byte-enabled write.
  logic [31:0] ram [DEPTH];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_rdata <= 32'h0;
    end else if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= ram[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_wen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input logic e_ig, input logic e_mg, input logic [9:0] e_addr,
                             input logic [3:0] e_wen, input logic e_irv, input logic e_mrv,
                             input logic [31:0] e_rd);
    check("if_gnt", 32'(if_gnt), 32'(e_ig));
    check("mem_gnt", 32'(mem_gnt), 32'(e_mg));
    check("ram_en", 32'(ram_en), 32'(e_ig | e_mg));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wen", 32'(ram_wen), 32'(e_wen));
    check("ram_wdata", ram_wdata, mem_wdata);
    check("if_rvalid", 32'(if_rvalid), 32'(e_irv));
    check("mem_rvalid", 32'(mem_rvalid), 32'(e_mrv));
    if (e_irv) check("if_rdata", if_rdata, e_rd);
    if (e_mrv) check("mem_rdata", mem_rdata, e_rd);
  endtask

  task automatic drive(input logic rst, input logic ifr, input logic [31:0] ifa,
                       input logic mr, input logic [3:0] mw, input logic [31:0] ma,
                       input logic [31:0] md);
    reset = rst; if_req = ifr; if_addr = ifa;
    mem_req = mr; mem_wen = mw; mem_addr = ma; mem_wdata = md;
  endtask

  typedef struct {
    logic rst, ifr; logic [31:0] ifa;
    logic mr; logic [3:0] mw; logic [31:0] ma, md;
    logic e_ig, e_mg; logic [9:0] e_addr; logic [3:0] e_wen;
    logic e_irv, e_mrv; logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[17];

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          lost;
  int          owner;     // 0 none, 1 IF, 2 MEM
  logic [31:0] exp_data;

  initial begin
    logic [31:0] L, I, M, S, Z;
    L = 32'h10; M = 32'h8; S = 32'h00AB0000; Z = 32'h0;
    I = 32'h0;
    //               rst   ifr   ifa mr    mw    ma md   ig    mg    addr  wen   irv   mrv   rd
    tbl[0]  = '{1'b1, 1'b1, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[1]  = '{1'b1, 1'b1, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[2]  = '{1'b0, 1'b0, L, 1'b0, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[3]  = '{1'b0, 1'b1, L, 1'b0, 4'h0, M, Z, 1'b1, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[4]  = '{1'b0, 1'b0, L, 1'b1, 4'h4, M, S, 1'b0, 1'b1, 10'd2, 4'h4, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b0, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b1, 10'd2, 4'h0, 1'b0, 1'b0, Z};
    tbl[6]  = '{1'b0, 1'b0, L, 1'b0, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b1, 32'h11AB3344};
    tbl[7]  = '{1'b0, 1'b1, L, 1'b0, 4'h0, M, Z, 1'b1, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[8]  = '{1'b0, 1'b0, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b1, 10'd2, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 1'b1, L, 1'b0, 4'h0, M, Z, 1'b1, 1'b0, 10'd4, 4'h0, 1'b0, 1'b1, 32'h11AB3344};
    tbl[10] = '{1'b0, 1'b0, L, 1'b0, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[11] = '{1'b0, 1'b1, L, 1'b0, 4'h0, M, Z, 1'b1, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[12] = '{1'b1, 1'b0, L, 1'b0, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[13] = '{1'b0, 1'b0, L, 1'b0, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};
    tbl[14] = '{1'b0, 1'b1, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b1, 10'd2, 4'h0, 1'b0, 1'b0, Z};
    tbl[15] = '{1'b0, 1'b1, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b1, 10'd2, 4'h0, 1'b0, 1'b1, 32'h11AB3344};
    tbl[16] = '{1'b1, 1'b1, L, 1'b1, 4'h0, M, Z, 1'b0, 1'b0, 10'd4, 4'h0, 1'b0, 1'b0, Z};

    preload = 1'b1;
    drive(1'b1, 1'b0, I, 1'b0, 4'h0, I, I);
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;

    // Directed vectors, one row per cycle
    for (int r = 0; r < 17; r++) begin
      if (r != 0) @(negedge clk);
      drive(tbl[r].rst, tbl[r].ifr, tbl[r].ifa, tbl[r].mr, tbl[r].mw, tbl[r].ma, tbl[r].md);
      #1;
      $display("vec %0d: rst=%b if_req=%b mem_req=%b -> if_gnt=%b mem_gnt=%b if_rv=%b mem_rv=%b",
               r, reset, if_req, mem_req, if_gnt, mem_gnt, if_rvalid, mem_rvalid);
      check_cycle(tbl[r].e_ig, tbl[r].e_mg, tbl[r].e_addr, tbl[r].e_wen,
                  tbl[r].e_irv, tbl[r].e_mrv, tbl[r].e_rd);
    end

    // Both requesting continuously: four MEM grants then one forced IF grant, repeating
    for (int k = 0; k < 10; k++) begin
      logic e_ig, p_ig;
      @(negedge clk);
      drive(1'b0, 1'b1, L, 1'b1, 4'h0, M, Z);
      #1;
      e_ig = (k % 5 == 4);
      p_ig = (k > 0) && ((k - 1) % 5 == 4);
      $display("starve %0d: if_gnt=%b mem_gnt=%b if_rv=%b mem_rv=%b",
               k, if_gnt, mem_gnt, if_rvalid, mem_rvalid);
      check_cycle(e_ig, !e_ig, e_ig ? 10'd4 : 10'd2, 4'h0, p_ig, (k > 0) && !p_ig,
                  p_ig ? 32'hDEADBEEF : 32'h11AB3344);
    end

    // Random traffic against the transaction-level model
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    ref_mem[2] = 32'h11AB3344;
    begin
      logic        if_pend, mem_pend, rst, e_ig, e_mg, e_irv, e_mrv;
      logic [31:0] ia, ma, md;
      logic [3:0]  mw;
      int          iidx, midx;
      if_pend = 1'b0; mem_pend = 1'b0; ia = 0; ma = 0; md = 0; mw = 0;
      lost = 0; owner = 0; exp_data = 0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        rst = (c == 0) || ($urandom_range(0, 39) == 0);
        if (if_pend && $urandom_range(0, 15) == 0) if_pend = 1'b0;
        else if (!if_pend && $urandom_range(0, 2) != 0) begin
          if_pend = 1'b1;
          ia = ($urandom_range(0, 15) << 28) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        end
        if (mem_pend && $urandom_range(0, 15) == 0) mem_pend = 1'b0;
        else if (!mem_pend && $urandom_range(0, 2) != 0) begin
          mem_pend = 1'b1;
          ma = ($urandom_range(0, 15) << 28) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
          mw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          md = $urandom;
        end
        drive(rst, if_pend, ia, mem_pend, mw, ma, md);
        #1;
        iidx  = int'((ia / 4) % DEPTH);
        midx  = int'((ma / 4) % DEPTH);
        e_ig  = !rst && if_pend && (!mem_pend || lost == LIMIT);
        e_mg  = !rst && mem_pend && !e_ig;
        e_irv = !rst && owner == 1;
        e_mrv = !rst && owner == 2;
        $display("rnd %0d: rst=%b if_req=%b mem_req=%b wen=%h -> if_gnt=%b mem_gnt=%b",
                 c, rst, if_pend, mem_pend, mw, if_gnt, mem_gnt);
        check_cycle(e_ig, e_mg, 10'(e_mg ? midx : iidx), e_mg ? mw : 4'h0,
                    e_irv, e_mrv, exp_data);
        if (rst) begin
          owner = 0;
          lost  = 0;
        end else begin
          owner = 0;
          if (e_ig) begin
            owner = 1; exp_data = ref_mem[iidx];
          end else if (e_mg && mw == 4'h0) begin
            owner = 2; exp_data = ref_mem[midx];
          end else if (e_mg) begin
            for (int b = 0; b < 4; b++)
              if (mw[b]) ref_mem[midx][8*b +: 8] = md[8*b +: 8];
          end
          lost = (if_pend && !e_ig) ? ((lost + 1 > LIMIT) ? LIMIT : lost + 1) : 0;
          if (e_ig) if_pend = 1'b0;
          if (e_mg) mem_pend = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
